mem_access_unit: RTL and testbench

Load/store access unit between the EX/MEM pipeline register and the byte-enabled data memory port. Converts a RISC-V load/store request (funct3, byte address, store data) into word-aligned memory transactions with byte enables. Splits accesses that cross a 32-bit word boundary into two back-to-back transactions, stalling the pipeline for one cycle. Returns sign- or zero-extended load data registered for the MEM/WB stage.

---
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store access unit: word-aligned byte-enabled memory port,
// splits word-crossing accesses into two back-to-back transactions.
module mem_access_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned_err,
  output logic [31:0] dmem_addr,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;

  logic        req, is_store, illegal, crossing;
  logic [1:0]  off;
  logic [2:0]  nbytes, rem;
  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] word_addr, rd_lo, rd_hi;

  logic        stall_c, rd_c, wr_c;
  logic [31:0] addr_c, wdata_c;
  logic [3:0]  be_c;
  logic        ld_upd, err_d;
  logic [31:0] ld_raw;

  function automatic logic [31:0] extend(
    input logic [31:0] raw,
    input logic [2:0]  f3
  );
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign req      = mem_read | mem_write;
  assign is_store = mem_write;
  assign off      = addr[1:0];

  // Loads: 011/110/111 illegal. Stores: any unsigned form or 011.
  assign illegal = is_store
    ? (funct3[2] | (funct3[1] & funct3[0]))
    : (funct3[1] & (funct3[0] | funct3[2]));

  always_comb begin
    mask   = 4'b1111;
    nbytes = 3'd4;
    case (funct3[1:0])
      2'b00: begin
        mask   = 4'b0001;
        nbytes = 3'd1;
      end
      2'b01: begin
        mask   = 4'b0011;
        nbytes = 3'd2;
      end
      default: begin
        mask   = 4'b1111;
        nbytes = 3'd4;
      end
    endcase
  end

  assign crossing  = ({1'b0, off} + nbytes) > 3'd4;
  assign rem       = 3'd4 - {1'b0, off};
  assign word_addr = {addr[31:2], 2'b00};

  // Low half of each wide vector feeds the first access, high half the second.
  assign be_wide = {4'b0000, mask} << off;
  assign wd_wide = {32'h0, write_data} << {off, 3'b000};
  assign rd_lo   = dmem_rdata >> {off, 3'b000};
  assign rd_hi   = dmem_rdata << {rem, 3'b000};

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stall_c = 1'b0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    addr_c  = 32'h0;
    be_c    = 4'b0000;
    wdata_c = 32'h0;
    ld_upd  = 1'b0;
    ld_raw  = 32'h0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (illegal || (crossing && !ALLOW_MISALIGNED)) begin
            err_d = 1'b1;
          end else begin
            addr_c  = word_addr;
            be_c    = be_wide[3:0];
            wdata_c = wd_wide[31:0];
            rd_c    = ~is_store;
            wr_c    = is_store;
            if (crossing) begin
              stall_c = 1'b1;
              state_d = SECOND;
              if (!is_store) hold_d = rd_lo;
            end else if (!is_store) begin
              ld_upd = 1'b1;
              ld_raw = rd_lo;
            end
          end
        end
      end
      SECOND: begin
        addr_c  = word_addr + 32'd4;
        be_c    = be_wide[7:4];
        wdata_c = wd_wide[63:32];
        rd_c    = ~is_store;
        wr_c    = is_store;
        ld_upd  = ~is_store;
        ld_raw  = hold_q | rd_hi;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset silences the memory port at once, even mid-split.
  assign stall      = stall_c & ~rst;
  assign dmem_read  = rd_c & ~rst;
  assign dmem_write = wr_c & ~rst;
  assign dmem_addr  = rst ? 32'h0 : addr_c;
  assign dmem_be    = rst ? 4'b0000 : be_c;
  assign dmem_wdata = rst ? 32'h0 : wdata_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      hold_q         <= 32'h0;
      load_data      <= 32'h0;
      load_valid     <= 1'b0;
      misaligned_err <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      load_valid     <= ld_upd;
      misaligned_err <= err_d;
      if (ld_upd) load_data <= extend(ld_raw, funct3);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, hand sequences for split
// accesses, errors and reset, plus a load scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, write_data;
  logic        stall, load_valid, misaligned_err;
  logic [31:0] load_data;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_read, dmem_write;
  logic [3:0]  dmem_be;

  logic        mem_read_b, mem_write_b;
  logic [2:0]  funct3_b;
  logic [31:0] addr_b, write_data_b;
  logic        stall_b, load_valid_b, misaligned_err_b;
  logic [31:0] load_data_b;
  logic [31:0] dmem_addr_b, dmem_wdata_b, dmem_rdata_b;
  logic        dmem_read_b, dmem_write_b;
  logic [3:0]  dmem_be_b;

  always #5 clk = ~clk;

  mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .write_data(write_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned_err(misaligned_err),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .mem_read(mem_read_b), .mem_write(mem_write_b),
    .funct3(funct3_b), .addr(addr_b), .write_data(write_data_b),
    .stall(stall_b), .load_data(load_data_b),
    .load_valid(load_valid_b),
    .misaligned_err(misaligned_err_b),
    .dmem_addr(dmem_addr_b), .dmem_read(dmem_read_b),
    .dmem_write(dmem_write_b), .dmem_be(dmem_be_b),
    .dmem_wdata(dmem_wdata_b), .dmem_rdata(dmem_rdata_b)
  );

  logic [31:0] mem [0:15];
  assign dmem_rdata = mem[dmem_addr[5:2]];

  always @(posedge clk) begin
    if (dmem_write) begin
      for (int i = 0; i < 4; i++)
        if (dmem_be[i]) mem[dmem_addr[5:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (load_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL load_valid: got unexpected pulse data %h", load_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("load_data", load_data, e.data);
        chk("load_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic push(input logic [31:0] d, input int lat);
    exp_t e;
    e.data = d;
    e.due  = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; funct3 = f3;
    addr = a; write_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic drive_b(input logic rd, input logic [2:0] f3,
                         input logic [31:0] a);
    mem_read_b = rd; mem_write_b = 1'b0; funct3_b = f3;
    addr_b = a; write_data_b = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic [31:0] ea, ewd, eld;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] ea,
                     input logic [31:0] ewd, input logic [31:0] eld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
    v.be = be; v.ea = ea; v.ewd = ewd; v.eld = eld;
    vecs.push_back(v);
  endtask

  initial begin
    idle();
    drive_b(1'b0, 3'b000, 32'h0);
    dmem_rdata_b = 32'hCAFEF00D;
    #1 rst = 1'b1;
    #2;
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_load_valid", {31'h0, load_valid}, 32'h0);
    chk("rst_err", {31'h0, misaligned_err}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_dmem_wr", {31'h0, dmem_write}, 32'h0);
    chk("rst_dmem_rd", {31'h0, dmem_read}, 32'h0);
    chk("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("idle_be", {28'h0, dmem_be}, 32'h0);
    chk("idle_wdata", dmem_wdata, 32'h0);

    add(0, 1, 3'b010, 32'h0, 32'h11223344, 4'hF, 32'h0, 32'h11223344, 0);
    add(1, 0, 3'b010, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0, 32'h11223344);
    add(0, 1, 3'b010, 32'h0, 32'h8899AABB, 4'hF, 32'h0, 32'h8899AABB, 0);
    add(0, 1, 3'b010, 32'h4, 32'h11223344, 4'hF, 32'h4, 32'h11223344, 0);
    add(1, 0, 3'b000, 32'h3, 32'h0, 4'h8, 32'h0, 32'h0, 32'hFFFFFF88);
    add(1, 0, 3'b100, 32'h3, 32'h0, 4'h8, 32'h0, 32'h0, 32'h00000088);
    add(1, 0, 3'b001, 32'h2, 32'h0, 4'hC, 32'h0, 32'h0, 32'hFFFF8899);
    add(1, 0, 3'b101, 32'h1, 32'h0, 4'h6, 32'h0, 32'h0, 32'h000099AA);
    add(1, 0, 3'b000, 32'h0, 32'h0, 4'h1, 32'h0, 32'h0, 32'hFFFFFFBB);
    add(1, 0, 3'b010, 32'h4, 32'h0, 4'hF, 32'h4, 32'h0, 32'h11223344);
    add(0, 1, 3'b000, 32'h1, 32'hCC, 4'h2, 32'h0, 32'h0000CC00, 0);
    add(1, 0, 3'b010, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0, 32'h8899CCBB);
    add(1, 0, 3'b001, 32'h0, 32'h0, 4'h3, 32'h0, 32'h0, 32'hFFFFCCBB);
    add(0, 1, 3'b000, 32'h1, 32'hAA, 4'h2, 32'h0, 32'h0000AA00, 0);

    foreach (vecs[i]) begin
      step();
      drive(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd);
      if (vecs[i].rd && !vecs[i].wr) push(vecs[i].eld, 1);
      @(negedge clk);
      chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].ea);
      chk($sformatf("v%0d_be", i), {28'h0, dmem_be}, {28'h0, vecs[i].be});
      chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].ewd);
      chk($sformatf("v%0d_rd", i), {31'h0, dmem_read},
          {31'h0, vecs[i].rd & ~vecs[i].wr});
      chk($sformatf("v%0d_wr", i), {31'h0, dmem_write}, {31'h0, vecs[i].wr});
      chk($sformatf("v%0d_stall", i), {31'h0, stall}, 32'h0);
    end

    // crossing LW at 2
    step();
    drive(1, 0, 3'b010, 32'h2, 32'h0);
    push(32'h33448899, 2);
    @(negedge clk);
    chk("xlw1_addr", dmem_addr, 32'h0);
    chk("xlw1_be", {28'h0, dmem_be}, 32'hC);
    chk("xlw1_stall", {31'h0, stall}, 32'h1);
    step();
    @(negedge clk);
    chk("xlw2_addr", dmem_addr, 32'h4);
    chk("xlw2_be", {28'h0, dmem_be}, 32'h3);
    chk("xlw2_stall", {31'h0, stall}, 32'h0);
    chk("xlw2_rd", {31'h0, dmem_read}, 32'h1);

    // crossing SH at 3, issued straight after SECOND
    step();
    drive(0, 1, 3'b001, 32'h3, 32'h0000BEEF);
    @(negedge clk);
    chk("xsh1_addr", dmem_addr, 32'h0);
    chk("xsh1_be", {28'h0, dmem_be}, 32'h8);
    chk("xsh1_wd", {24'h0, dmem_wdata[31:24]}, 32'hEF);
    chk("xsh1_stall", {31'h0, stall}, 32'h1);
    step();
    @(negedge clk);
    chk("xsh2_addr", dmem_addr, 32'h4);
    chk("xsh2_be", {28'h0, dmem_be}, 32'h1);
    chk("xsh2_wd", {24'h0, dmem_wdata[7:0]}, 32'hBE);
    chk("xsh2_wr", {31'h0, dmem_write}, 32'h1);
    chk("xsh2_stall", {31'h0, stall}, 32'h0);
    step();
    drive(1, 0, 3'b101, 32'h3, 32'h0);
    push(32'h0000BEEF, 2);
    @(negedge clk);
    chk("xlhu1_stall", {31'h0, stall}, 32'h1);
    step();
    @(negedge clk);
    chk("xlhu2_be", {28'h0, dmem_be}, 32'h1);

    // illegal load funct3 110
    step();
    drive(1, 0, 3'b110, 32'h0, 32'h0);
    @(negedge clk);
    chk("ill_rd", {31'h0, dmem_read}, 32'h0);
    chk("ill_be", {28'h0, dmem_be}, 32'h0);
    chk("ill_stall", {31'h0, stall}, 32'h0);
    chk("ill_err_early", {31'h0, misaligned_err}, 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("ill_err", {31'h0, misaligned_err}, 32'h1);
    step();
    @(negedge clk);
    chk("ill_err_end", {31'h0, misaligned_err}, 32'h0);

    // ALLOW_MISALIGNED = 0: LW at 1 suppressed, aligned LH still served
    step();
    drive_b(1, 3'b010, 32'h1);
    @(negedge clk);
    chk("nm_rd", {31'h0, dmem_read_b}, 32'h0);
    chk("nm_wr", {31'h0, dmem_write_b}, 32'h0);
    chk("nm_stall", {31'h0, stall_b}, 32'h0);
    step();
    drive_b(1, 3'b001, 32'h2);
    @(negedge clk);
    chk("nm_err", {31'h0, misaligned_err_b}, 32'h1);
    chk("nm_lh_be", {28'h0, dmem_be_b}, 32'hC);
    step();
    drive_b(0, 3'b000, 32'h0);
    @(negedge clk);
    chk("nm_err_end", {31'h0, misaligned_err_b}, 32'h0);
    chk("nm_lh_valid", {31'h0, load_valid_b}, 32'h1);
    chk("nm_lh_data", load_data_b, 32'hFFFFCAFE);

    // reset during SECOND of crossing SW at 10
    step();
    drive(0, 1, 3'b010, 32'h8, 32'h0);
    step();
    drive(0, 1, 3'b010, 32'hC, 32'h0);
    step();
    drive(0, 1, 3'b010, 32'hA, 32'hA1B2C3D4);
    @(negedge clk);
    chk("xsw1_stall", {31'h0, stall}, 32'h1);
    chk("xsw1_wdata", dmem_wdata, 32'hC3D40000);
    step();
    @(negedge clk);
    chk("xsw2_addr", dmem_addr, 32'hC);
    chk("xsw2_be", {28'h0, dmem_be}, 32'h3);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_wr", {31'h0, dmem_write}, 32'h0);
    chk("mid_rst_be", {28'h0, dmem_be}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_load_data", load_data, 32'h0);
    chk("mid_rst_load_valid", {31'h0, load_valid}, 32'h0);
    step();
    idle();
    rst = 1'b0;
    step();
    drive(1, 0, 3'b010, 32'h8, 32'h0);
    push(32'hC3D40000, 1);
    @(negedge clk);
    chk("post_rst_stall", {31'h0, stall}, 32'h0);
    chk("post_rst_be", {28'h0, dmem_be}, 32'hF);
    step();
    drive(1, 0, 3'b010, 32'hC, 32'h0);
    push(32'h00000000, 1);
    step();
    idle();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
